// File: rtl/serial_tx_block.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bit on an idle-high line.
// Define PARITY_EN to compile in the parity bit; the default build sends no parity.
module serial_tx_block #(
  parameter int BIT_PERIOD = 10,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy
);

  localparam int CNT_W = $clog2(BIT_PERIOD);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_PERIOD = CNT_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_out_q, serial_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 period_end;
`ifdef PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign period_end = (period_q == LAST_PERIOD);

  // serial_d is the line level for the cycle after this edge, so the output stays a bare flop
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    serial_out_d = serial_out_q;
`ifdef PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        serial_out_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          state_d      = START;
          serial_out_d = 1'b0;
          period_d     = '0;
          bit_d        = '0;
          shift_d      = tx_data;
`ifdef PARITY_EN
          parity_d     = ^tx_data;
`endif
        end
      end
      START: begin
        if (period_end) begin
          state_d      = DATA;
          period_d     = '0;
          serial_out_d = shift_q[0];
        end else begin
          period_d = period_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          period_d = '0;
          shift_d  = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef PARITY_EN
            state_d      = PARITY;
            serial_out_d = parity_q;
`else
            state_d      = STOP;
            serial_out_d = 1'b1;
`endif
          end else begin
            bit_d        = bit_q + BIT_W'(1);
            serial_out_d = shift_q[1];
          end
        end else begin
          period_d = period_q + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (period_end) begin
          state_d      = STOP;
          period_d     = '0;
          serial_out_d = 1'b1;
        end else begin
          period_d = period_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        serial_out_d = 1'b1;
        if (period_end) begin
          state_d  = IDLE;
          period_d = '0;
        end else begin
          period_d = period_q + CNT_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        period_d     = '0;
        bit_d        = '0;
        serial_out_d = 1'b1;
      end
    endcase
    tx_ready_d = (state_d == IDLE);
    tx_busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      period_q     <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      serial_out_q <= 1'b1;
      tx_ready_q   <= 1'b1;
      tx_busy_q    <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      tx_ready_q   <= tx_ready_d;
      tx_busy_q    <= tx_busy_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign serial_out = serial_out_q;
  assign tx_ready   = tx_ready_q;
  assign tx_busy    = tx_busy_q;

endmodule
